pifo_flow_ctrl: RTL and testbench

PIFO_FLOW_CTRL -- requirements
Module: pifo_flow_ctrl

---
 rtl/pifo_pkg.sv | 24 ++
 rtl/pifo_out_reg.sv | 43 ++++
 rtl/pifo_flow_ctrl.sv | 131 +++++++++++++
 tb/tb_pifo_flow_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared types for the PIFO flow controller: priority-width helper, FSM states
// and the flow descriptor used when a flow enters the PIFO set.
package pifo_pkg;

    function automatic int prio_width_f(input int max_priority);
        return (max_priority > 2) ? $clog2(max_priority) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fc_state_e;

    localparam int DESC_ID_W   = 8;
    localparam int DESC_PRIO_W = 8;

    // Flow descriptor at the default widths: what the PIFO set stores per flow.
    typedef struct packed {
        logic [DESC_ID_W-1:0]   flow_id;
        logic [DESC_PRIO_W-1:0] prio;
    } flow_desc_t;

endpackage

// File: rtl/pifo_out_reg.sv
// Single valid/ready register stage carrying the dequeued flow id.
module pifo_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__load,
    input  logic [DATA_WIDTH-1:0] i__load_data,
    input  logic                  i__ready,
    output logic                  o__valid,
    output logic [DATA_WIDTH-1:0] o__data
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A load wins over a drain so a pop during a consuming handshake refills the stage.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i__load) begin
            valid_d = 1'b1;
            data_d  = i__load_data;
        end else if (i__ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o__valid = valid_q;
    assign o__data  = data_q;

endmodule

// File: rtl/pifo_flow_ctrl.sv
// Per-flow packet counting in front of a PIFO set: pushes newly active flows,
// reinserts flows that still hold packets after a pop, and supports a flush/drain.
module pifo_flow_ctrl
    import pifo_pkg::*;
#(
    parameter int  NUM_FLOWS    = 16,
    parameter int  MAX_PRIORITY = 256,
    parameter int  DATA_WIDTH   = 8,
    parameter int  CNT_WIDTH    = 8,
    parameter int  PRIO_DECR    = 1,
    localparam int PRIO_WIDTH   = prio_width_f(MAX_PRIORITY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__arr_valid,
    input  logic [DATA_WIDTH-1:0] i__arr_flow_id,
    input  logic [PRIO_WIDTH-1:0] i__arr_priority,
    output logic                  o__arr_ready,
    output logic                  o__push_valid,
    output logic [PRIO_WIDTH-1:0] o__push_priority,
    output logic [DATA_WIDTH-1:0] o__push_flow_id,
    input  logic                  i__pifo_set_ready,
    input  logic                  i__pop_valid,
    input  logic [PRIO_WIDTH-1:0] i__pop_priority,
    input  logic [DATA_WIDTH-1:0] i__pop_flow_id,
    output logic                  o__pop,
    output logic                  o__reinsert_valid,
    output logic [PRIO_WIDTH-1:0] o__reinsert_priority,
    output logic                  o__deq_valid,
    output logic [DATA_WIDTH-1:0] o__deq_flow_id,
    input  logic                  i__deq_ready,
    input  logic                  i__flush,
    output logic                  o__flush_done,
    output logic                  o__busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_FLOWS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_FLOWS];
    fc_state_e            state_q, state_d;

    logic [CNT_WIDTH-1:0] arr_cnt;
    logic                 arr_acc;
    logic                 pop_fire;
    logic                 all_idle;
    logic                 pop_cnt_next_nz;
    logic                 deq_valid;
    logic                 inc, dec;

    // Ids beyond NUM_FLOWS read as full, so such arrivals are never accepted.
    always_comb begin
        arr_cnt = CNT_MAX;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (i__arr_flow_id == DATA_WIDTH'(f)) arr_cnt = cnt_q[f];
        end
    end

    always_comb begin
        o__arr_ready     = reset && (state_q == ST_RUN) && i__pifo_set_ready && (arr_cnt != CNT_MAX);
        arr_acc          = i__arr_valid && o__arr_ready;
        pop_fire         = reset && i__pop_valid && (!deq_valid || i__deq_ready);
        o__pop           = pop_fire;
        o__push_valid    = arr_acc && (arr_cnt == '0)
                           && !(pop_fire && (i__pop_flow_id == i__arr_flow_id));
        o__push_priority = i__arr_priority;
        o__push_flow_id  = i__arr_flow_id;
        o__reinsert_valid = pop_fire && pop_cnt_next_nz;
        if (int'(i__pop_priority) >= PRIO_DECR)
            o__reinsert_priority = i__pop_priority - PRIO_WIDTH'(PRIO_DECR);
        else
            o__reinsert_priority = '0;
        o__flush_done    = reset && (state_q == ST_DONE);
        o__busy          = reset && (state_q != ST_RUN);
    end

    // Arrival and pop on the same flow cancel out; counters saturate instead of wrapping.
    always_comb begin
        all_idle        = 1'b1;
        pop_cnt_next_nz = 1'b0;
        inc             = 1'b0;
        dec             = 1'b0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            inc      = arr_acc  && (i__arr_flow_id == DATA_WIDTH'(f));
            dec      = pop_fire && (i__pop_flow_id == DATA_WIDTH'(f));
            cnt_d[f] = cnt_q[f];
            if (inc && !dec && (cnt_q[f] != CNT_MAX))
                cnt_d[f] = cnt_q[f] + CNT_WIDTH'(1);
            else if (dec && !inc && (cnt_q[f] != '0))
                cnt_d[f] = cnt_q[f] - CNT_WIDTH'(1);
            if (cnt_q[f] != '0) all_idle = 1'b0;
            if ((i__pop_flow_id == DATA_WIDTH'(f)) && (cnt_d[f] != '0)) pop_cnt_next_nz = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (i__flush) state_d = ST_DRAIN;
            ST_DRAIN: if (all_idle && !deq_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // NOTE: the counter array is reset explicitly; a non-zero count marks a flow live in the PIFO set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            for (int f = 0; f < NUM_FLOWS; f++) cnt_q[f] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pifo_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .i__load      (pop_fire),
        .i__load_data (i__pop_flow_id),
        .i__ready     (i__deq_ready),
        .o__valid     (deq_valid),
        .o__data      (o__deq_flow_id)
    );

    assign o__deq_valid = deq_valid;

endmodule

// File: tb/tb_pifo_flow_ctrl.sv
// Scoreboard bench for pifo_flow_ctrl: the stimulus side plays the PIFO set and
// queues expected responses; a negedge monitor compares whatever the DUT presents.
module tb_pifo_flow_ctrl;
    import pifo_pkg::*;

    localparam int NF   = 16;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i__arr_valid = 1'b0;
    logic [7:0] i__arr_flow_id = '0;
    logic [7:0] i__arr_priority = '0;
    logic       o__arr_ready;
    logic       o__push_valid;
    logic [7:0] o__push_priority;
    logic [7:0] o__push_flow_id;
    logic       i__pifo_set_ready = 1'b0;
    logic       i__pop_valid = 1'b0;
    logic [7:0] i__pop_priority = '0;
    logic [7:0] i__pop_flow_id = '0;
    logic       o__pop;
    logic       o__reinsert_valid;
    logic [7:0] o__reinsert_priority;
    logic       o__deq_valid;
    logic [7:0] o__deq_flow_id;
    logic       i__deq_ready = 1'b0;
    logic       i__flush = 1'b0;
    logic       o__flush_done;
    logic       o__busy;

    always #5 clk = ~clk;

    pifo_flow_ctrl #(
        .NUM_FLOWS (NF), .MAX_PRIORITY (256), .DATA_WIDTH (8), .CNT_WIDTH (8), .PRIO_DECR (1)
    ) dut (
        .clk (clk), .reset (reset),
        .i__arr_valid (i__arr_valid), .i__arr_flow_id (i__arr_flow_id),
        .i__arr_priority (i__arr_priority), .o__arr_ready (o__arr_ready),
        .o__push_valid (o__push_valid), .o__push_priority (o__push_priority),
        .o__push_flow_id (o__push_flow_id), .i__pifo_set_ready (i__pifo_set_ready),
        .i__pop_valid (i__pop_valid), .i__pop_priority (i__pop_priority),
        .i__pop_flow_id (i__pop_flow_id), .o__pop (o__pop),
        .o__reinsert_valid (o__reinsert_valid), .o__reinsert_priority (o__reinsert_priority),
        .o__deq_valid (o__deq_valid), .o__deq_flow_id (o__deq_flow_id),
        .i__deq_ready (i__deq_ready), .i__flush (i__flush),
        .o__flush_done (o__flush_done), .o__busy (o__busy)
    );

    typedef struct {
        bit       arr_ready, pop, push_valid, reinsert_valid, flush_done, busy, deq_valid;
        bit [7:0] deq_flow;
    } ctl_t;

    typedef enum int {M_RUN, M_DRAIN, M_DONE} mst_t;

    ctl_t       ctl_q[$];
    flow_desc_t push_q[$];
    bit [7:0]   reins_q[$];
    bit [7:0]   deq_q[$];

    int   m_cnt  [NF];
    bit   m_in   [NF];
    int   m_prio [NF];
    bit   m_dv;
    int   m_df;
    mst_t m_state;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int f = 0; f < NF; f++) begin
            m_cnt[f] = 0; m_in[f] = 0; m_prio[f] = 0;
        end
        m_dv = 0; m_df = 0; m_state = M_RUN;
    endtask

    // One clock cycle: choose a pop from the modelled PIFO set, drive inputs,
    // queue every expected response, then advance the reference model.
    task automatic drive_cycle(input bit av, input int af, input int ap, input bit pop_en,
                               input int pop_sel, input bit srdy, input bit drdy, input bit fl);
        int pf, pp, best, rp;
        bit pv, arr_ok, acc, exp_pop, push, reins, all_zero;
        ctl_t c;
        mst_t nst;
        flow_desc_t d;
        @(posedge clk); #1;
        pv = 0; pf = 0; pp = 0;
        if (pop_en) begin
            if (pop_sel >= 0) begin
                if (m_in[pop_sel]) begin pv = 1; pf = pop_sel; end
            end else begin
                best = -1;
                for (int f = 0; f < NF; f++)
                    if (m_in[f] && (best < 0 || m_prio[f] < m_prio[best])) best = f;
                if (best >= 0) begin pv = 1; pf = best; end
            end
            if (pv) pp = m_prio[pf];
        end
        i__arr_valid = av; i__arr_flow_id = 8'(af); i__arr_priority = 8'(ap);
        i__pop_valid = pv; i__pop_flow_id = 8'(pf); i__pop_priority = 8'(pp);
        i__pifo_set_ready = srdy; i__deq_ready = drdy; i__flush = fl;

        arr_ok  = (m_state == M_RUN) && srdy && (m_cnt[af] != CMAX);
        acc     = av && arr_ok;
        exp_pop = pv && (!m_dv || drdy);
        push    = acc && (m_cnt[af] == 0) && !(exp_pop && pf == af);

        c.arr_ready  = arr_ok;
        c.pop        = exp_pop;
        c.push_valid = push;
        c.flush_done = (m_state == M_DONE);
        c.busy       = (m_state != M_RUN);
        c.deq_valid  = m_dv;
        c.deq_flow   = 8'(m_df);

        all_zero = 1;
        for (int f = 0; f < NF; f++) if (m_cnt[f] != 0) all_zero = 0;
        nst = m_state;
        case (m_state)
            M_RUN:   if (fl) nst = M_DRAIN;
            M_DRAIN: if (all_zero && !m_dv) nst = M_DONE;
            default: nst = M_RUN;
        endcase

        if (acc) m_cnt[af]++;
        if (exp_pop) m_cnt[pf]--;
        reins = exp_pop && (m_cnt[pf] > 0);
        rp    = (pp >= 1) ? pp - 1 : 0;
        c.reinsert_valid = reins;
        ctl_q.push_back(c);

        if (push) begin d.flow_id = 8'(af); d.prio = 8'(ap); push_q.push_back(d); end
        if (reins) reins_q.push_back(8'(rp));
        if (m_dv && drdy) deq_q.push_back(8'(m_df));

        if (exp_pop) m_in[pf] = 0;
        if (reins) begin m_in[pf] = 1; m_prio[pf] = rp; end
        if (push) begin m_in[af] = 1; m_prio[af] = ap; end
        if (exp_pop) begin m_dv = 1; m_df = pf; end
        else if (drdy) m_dv = 0;
        m_state = nst;
    endtask

    always @(negedge clk) begin : monitor
        ctl_t c;
        flow_desc_t d;
        bit [7:0] r;
        if (reset && ctl_q.size() > 0) begin
            c = ctl_q.pop_front();
            check("arr_ready", o__arr_ready, c.arr_ready);
            check("pop", o__pop, c.pop);
            check("push_valid", o__push_valid, c.push_valid);
            check("reinsert_valid", o__reinsert_valid, c.reinsert_valid);
            check("flush_done", o__flush_done, c.flush_done);
            check("busy", o__busy, c.busy);
            check("deq_valid", o__deq_valid, c.deq_valid);
            if (c.deq_valid) check("deq_flow_id", o__deq_flow_id, c.deq_flow);
            if (o__push_valid) begin
                if (push_q.size() == 0) check("push_unexpected", 1, 0);
                else begin
                    d = push_q.pop_front();
                    check("push_flow_id", o__push_flow_id, d.flow_id);
                    check("push_priority", o__push_priority, d.prio);
                end
            end
            if (o__reinsert_valid) begin
                if (reins_q.size() == 0) check("reinsert_unexpected", 1, 0);
                else begin
                    r = reins_q.pop_front();
                    check("reinsert_priority", o__reinsert_priority, r);
                end
            end
            if (o__deq_valid && i__deq_ready) begin
                if (deq_q.size() == 0) check("deq_unexpected", 1, 0);
                else begin
                    r = deq_q.pop_front();
                    check("deq_handshake_flow", o__deq_flow_id, r);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        i__arr_valid = 1; i__arr_flow_id = 8'd1; i__pop_valid = 1; i__pop_flow_id = 8'd1;
        i__pifo_set_ready = 1; i__deq_ready = 1; i__flush = 1;
        @(negedge clk);
        check("rst_arr_ready", o__arr_ready, 0);
        check("rst_push_valid", o__push_valid, 0);
        check("rst_pop", o__pop, 0);
        check("rst_reinsert_valid", o__reinsert_valid, 0);
        check("rst_flush_done", o__flush_done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_deq_valid", o__deq_valid, 0);
        check("rst_deq_flow_id", o__deq_flow_id, 0);
        @(posedge clk); #1;
        reset = 1;
        i__arr_valid = 0; i__arr_flow_id = 8'd0; i__pop_valid = 0; i__pop_flow_id = 8'd0;
        i__deq_ready = 0; i__flush = 0;
        clear_model();
        @(negedge clk);
        check("post_rst_busy", o__busy, 0);
        check("post_rst_arr_ready", o__arr_ready, 1);
    endtask

    task automatic run_flush(input bit rand_deq);
        int k;
        drive_cycle(0, 0, 0, 0, -1, 1, 1, 1);
        k = 0;
        while (m_state != M_RUN && k < 3000) begin
            drive_cycle($urandom_range(0, 1), $urandom_range(0, NF - 1), $urandom_range(0, 255),
                        1, -1, 1, rand_deq ? ($urandom_range(0, 2) != 0) : 1'b1, 0);
            k++;
        end
        check("flush_completes_in_bound", int'(k < 3000), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        do_reset();

        // Push of a new flow, then pop with reinsert and decremented priority.
        drive_cycle(1, 3, 200, 0, -1, 1, 1, 0);
        drive_cycle(1, 3, 50, 0, -1, 1, 1, 0);
        drive_cycle(0, 0, 0, 1, 3, 1, 1, 0);
        drive_cycle(0, 0, 0, 0, -1, 1, 1, 0);

        // Pop of flow 5 at priority 0 with a same-cycle arrival: saturated reinsert, no push.
        drive_cycle(1, 5, 0, 0, -1, 1, 1, 0);
        drive_cycle(1, 5, 77, 1, 5, 1, 1, 0);

        // Output stalled: pop held off and deq output frozen until ready returns.
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 3, 1, 0, 0);
        drive_cycle(0, 0, 0, 1, 3, 1, 1, 0);
        run_flush(0);

        // Fill flow 7 to saturation, then probe readiness for flows 7, 8 and set-not-ready.
        for (int i = 0; i < CMAX; i++) drive_cycle(1, 7, $urandom_range(0, 255), 0, -1, 1, 1, 0);
        drive_cycle(1, 7, 10, 0, -1, 1, 1, 0);
        drive_cycle(1, 8, 20, 0, -1, 1, 1, 0);
        drive_cycle(1, 9, 30, 0, -1, 0, 1, 0);

        // Several flows queued, then a drain with a randomly stalling consumer.
        drive_cycle(1, 1, 5, 0, -1, 1, 1, 0);
        drive_cycle(1, 2, 6, 0, -1, 1, 1, 0);
        run_flush(1);

        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(0, 3) != 0,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, NF - 1) : $urandom_range(0, 3),
                        $urandom_range(0, 255), $urandom_range(0, 2) != 0, -1,
                        $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 299) == 0);
        end

        // Reset in the middle of traffic with a dequeue pending.
        drive_cycle(1, 4, 9, 0, -1, 1, 1, 0);
        drive_cycle(0, 0, 0, 1, 4, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive_cycle($urandom_range(0, 1), $urandom_range(0, NF - 1), $urandom_range(0, 255),
                        $urandom_range(0, 1), -1, 1, $urandom_range(0, 1), 0);
        end
        run_flush(1);

        @(negedge clk);
        @(negedge clk);
        check("push_q_drained", push_q.size(), 0);
        check("reinsert_q_drained", reins_q.size(), 0);
        check("deq_q_drained", deq_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
